// File: rtl/mips_pkg.sv
// mips_pkg -- shared types for the instruction fetch path.
//   word_t        : 32-bit machine word
//   fetch_state_e : fetch controller states
//   RESET_PC_DEFAULT, word_align() helper
package mips_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam word_t RESET_PC_DEFAULT = 32'h0040_0000;

    function automatic word_t word_align(input word_t a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if -- instruction memory request/response bundle.
//   imem_req   : request valid (master -> slave)
//   imem_addr  : word-aligned fetch address (master -> slave)
//   imem_ack   : response valid (slave -> master)
//   imem_rdata : instruction word, valid with imem_ack (slave -> master)
interface fetch_ctrl_if;
    import mips_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ack;
    word_t imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);

endinterface

// File: rtl/fetch_perf_cnt.sv
// fetch_perf_cnt -- saturating 32-bit event counter for fetch stalls.
// Only compiled when FETCH_CTRL_PERF_EN is defined.
//   clk, rst_n : clock, async active-low reset
//   inc_i      : count this cycle
//   cnt_o      : current count, sticks at 32'hFFFF_FFFF
`ifdef FETCH_CTRL_PERF_EN
module fetch_perf_cnt
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  inc_i,
    output word_t cnt_o
);

    word_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction fetch controller between PC, imem and decode.
//   clk, rst_n       : clock, async active-low reset
//   stall_f          : hold the fetch/decode boundary
//   redirect_valid/pc: taken branch/jump target from decode (pulse)
//   imem             : fetch_ctrl_if.master (req/addr out, ack/rdata in)
//   pc_en, pc_next   : combinational PC-advance strobe and next PC
//   instr_valid_d, instr_d, pc_plus4_d : registered decode-stage outputs
//   stall_cnt        : stalled-cycle count, present only with FETCH_CTRL_PERF_EN
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// FETCH | request at fetch PC outstanding
// HOLD  | word buffered while decode stalled, no request
// DRAIN | redirected with old request unanswered; wait, discard its word
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall_f,
    input  logic  redirect_valid,
    input  word_t redirect_pc,
    fetch_ctrl_if.master imem,
    output logic  pc_en,
    output word_t pc_next,
    output logic  instr_valid_d,
    output word_t instr_d,
    output word_t pc_plus4_d
`ifdef FETCH_CTRL_PERF_EN
    ,
    output word_t stall_cnt
`endif
);

    fetch_state_e state_q, state_d;
    word_t pc_q, addr_q, buf_q;
    logic  req_q;
    word_t pc_inc, redir_tgt, pc_after;
    logic  ack;

    assign ack       = imem.imem_ack;
    assign pc_inc    = pc_q + 32'd4;
    assign redir_tgt = word_align(redirect_pc);
    assign pc_after  = pc_en ? pc_next : pc_q;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    // Redirects are ignored in IDLE so pc_en stays low through reset.
    always_comb begin
        state_d = state_q;
        pc_en   = 1'b0;
        pc_next = pc_inc;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_en   = 1'b1;
                    pc_next = redir_tgt;
                    state_d = ack ? ST_FETCH : ST_DRAIN;
                end else if (ack) begin
                    if (stall_f) state_d = ST_HOLD;
                    else         pc_en   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_en   = 1'b1;
                    pc_next = redir_tgt;
                    state_d = ST_FETCH;
                end else if (!stall_f) begin
                    pc_en   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_en   = 1'b1;
                    pc_next = redir_tgt;
                end
                // The old word lands now; the (possibly new) PC is fetched next.
                if (ack) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            addr_q        <= RESET_PC;
            req_q         <= 1'b0;
            buf_q         <= '0;
            instr_valid_d <= 1'b0;
            instr_d       <= '0;
            pc_plus4_d    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_after;
            req_q   <= (state_d == ST_FETCH) || (state_d == ST_DRAIN);
            // In DRAIN the address stays on the abandoned request.
            if (state_d == ST_FETCH) addr_q <= pc_after;
            if ((state_q == ST_FETCH) && ack && stall_f && !redirect_valid)
                buf_q <= imem.imem_rdata;
            if (state_q != ST_IDLE) begin
                if (redirect_valid) begin
                    instr_valid_d <= 1'b0;
                end else if (!stall_f) begin
                    case (state_q)
                        ST_FETCH: begin
                            instr_valid_d <= ack;
                            if (ack) begin
                                instr_d    <= imem.imem_rdata;
                                pc_plus4_d <= pc_inc;
                            end
                        end
                        ST_HOLD: begin
                            instr_valid_d <= 1'b1;
                            instr_d       <= buf_q;
                            pc_plus4_d    <= pc_inc;
                        end
                        default: instr_valid_d <= 1'b0;
                    endcase
                end
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    fetch_perf_cnt u_perf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_f && (state_q != ST_IDLE)),
        .cnt_o (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl: directed scenarios
// plus randomized traffic against a transaction-level reference model.
// Build with FETCH_CTRL_PERF_EN defined to also check stall_cnt.
module tb_fetch_ctrl;
    import mips_pkg::*;

    localparam word_t RPC = 32'h0040_0000;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  stall_f = 1'b0;
    logic  redirect_valid = 1'b0;
    word_t redirect_pc = '0;
    logic  pc_en, instr_valid_d;
    word_t pc_next, instr_d, pc_plus4_d;
`ifdef FETCH_CTRL_PERF_EN
    word_t stall_cnt;
`endif

    fetch_ctrl_if imem_bus ();

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_f        (stall_f),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .pc_en          (pc_en),
        .pc_next        (pc_next),
        .instr_valid_d  (instr_valid_d),
        .instr_d        (instr_d),
        .pc_plus4_d     (pc_plus4_d)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    // Reference model: live = past the post-reset cycle, held = a word is
    // parked waiting for decode, junk = the memory's pending answer is stale.
    logic  m_live, m_held, m_junk, m_v, pend;
    word_t m_pc, m_old, m_buf, m_i, m_p4, m_cnt;
    logic  e_req, e_pc_en;
    word_t e_addr, e_pc_next;

    task automatic model_reset();
        m_live = 0; m_held = 0; m_junk = 0; m_v = 0; pend = 0;
        m_pc = RPC; m_old = RPC; m_buf = 0; m_i = 0; m_p4 = 0; m_cnt = 0;
    endtask

    task automatic deliver(input word_t w);
        m_v = 1; m_i = w; m_p4 = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_held = 0;
    endtask

    // Expected values for the cycle whose inputs are currently applied.
    task automatic model_exp();
        logic acc;
        acc = imem_bus.imem_ack && m_live && !m_held;
        e_req = m_live && !m_held;
        e_addr = m_junk ? m_old : m_pc;
        e_pc_en = 0;
        e_pc_next = 0;
        if (m_live) begin
            if (redirect_valid) begin
                e_pc_en = 1; e_pc_next = redirect_pc & 32'hFFFF_FFFC;
            end else if ((m_held && !stall_f) || (!m_held && !m_junk && acc && !stall_f)) begin
                e_pc_en = 1; e_pc_next = m_pc + 32'd4;
            end
        end
    endtask

    // Move the model across the clock edge using the inputs still applied.
    task automatic model_advance();
        logic acc;
        word_t tgt;
        acc = imem_bus.imem_ack && m_live && !m_held;
        tgt = redirect_pc & 32'hFFFF_FFFC;
        if (m_live && stall_f && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (!m_live) begin
            m_live = 1;
            return;
        end
        if (redirect_valid) begin
            m_v = 0;
            if (m_held) m_held = 0;
            else if (m_junk) begin
                if (acc) m_junk = 0;
            end else if (!acc) begin
                m_junk = 1; m_old = m_pc;
            end
            m_pc = tgt;
        end else if (m_held) begin
            if (!stall_f) deliver(m_buf);
        end else if (m_junk) begin
            if (acc) m_junk = 0;
            if (!stall_f) m_v = 0;
        end else if (acc) begin
            if (stall_f) begin m_held = 1; m_buf = imem_bus.imem_rdata; end
            else deliver(imem_bus.imem_rdata);
        end else if (!stall_f) begin
            m_v = 0;
        end
    endtask

    // Assert reset mid high phase; released by the next drive().
    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst_n = 0;
        stall_f = 0; redirect_valid = 0; redirect_pc = 0;
        imem_bus.imem_ack = 0; imem_bus.imem_rdata = 0;
        model_reset();
    endtask

    // One cycle: inputs applied at negedge, outputs valid 1ns later.
    // gate=1 restricts ack to cycles where a request is expected.
    task automatic drive(input logic st, input logic rd, input word_t rpc,
                         input logic ak, input word_t rdt, input logic gate);
        @(negedge clk);
        if (pend) model_advance();
        pend = 1;
        if (!rst_n) rst_n = 1;
        stall_f = st;
        redirect_valid = rd;
        redirect_pc = rpc;
        imem_bus.imem_ack = ak & (gate ? (m_live && !m_held) : 1'b1);
        imem_bus.imem_rdata = rdt;
        #1;
        model_exp();
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %0h want 0", imem_bus.imem_req); end
        total++; if (pc_en !== 1'b0) begin bad++; $display("FAIL reset_pc_en got %0h want 0", pc_en); end
        total++; if (instr_valid_d !== 1'b0) begin bad++; $display("FAIL reset_valid got %0h want 0", instr_valid_d); end
        total++; if (instr_d !== 32'h0) begin bad++; $display("FAIL reset_instr got %h want 0", instr_d); end
        total++; if (pc_plus4_d !== 32'h0) begin bad++; $display("FAIL reset_pc4 got %h want 0", pc_plus4_d); end
    endtask

    task automatic test_seq();
        apply_reset();
        drive(0, 0, 0, 1, 32'h1111_0000, 0);
        total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL seq_idle_req got %0h want 0", imem_bus.imem_req); end
        drive(0, 0, 0, 1, 32'h1111_0001, 0);
        total++; if (imem_bus.imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL seq_addr0 got %h want 00400000", imem_bus.imem_addr); end
        total++; if (instr_valid_d !== 1'b0) begin bad++; $display("FAIL seq_valid_early got %0h want 0", instr_valid_d); end
        total++; if (pc_next !== 32'h0040_0004 || pc_en !== 1'b1) begin bad++; $display("FAIL seq_pc_next got %h/%0h want 00400004/1", pc_next, pc_en); end
        drive(0, 0, 0, 1, 32'h1111_0002, 0);
        total++; if (imem_bus.imem_addr !== 32'h0040_0004) begin bad++; $display("FAIL seq_addr1 got %h want 00400004", imem_bus.imem_addr); end
        total++; if (instr_valid_d !== 1'b1 || instr_d !== 32'h1111_0001) begin bad++; $display("FAIL seq_instr1 got %0h/%h want 1/11110001", instr_valid_d, instr_d); end
        total++; if (pc_plus4_d !== 32'h0040_0004) begin bad++; $display("FAIL seq_pc4 got %h want 00400004", pc_plus4_d); end
        drive(0, 0, 0, 1, 32'h1111_0003, 0);
        total++; if (imem_bus.imem_addr !== 32'h0040_0008) begin bad++; $display("FAIL seq_addr2 got %h want 00400008", imem_bus.imem_addr); end
        total++; if (instr_d !== 32'h1111_0002) begin bad++; $display("FAIL seq_instr2 got %h want 11110002", instr_d); end
    endtask

    task automatic test_hold();
        apply_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 32'h8C01_0004, 0);
        total++; if (pc_en !== 1'b0) begin bad++; $display("FAIL hold_pc_en got %0h want 0", pc_en); end
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0, 0, 0);
            total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL hold_req got %0h want 0", imem_bus.imem_req); end
            total++; if (instr_valid_d !== 1'b0) begin bad++; $display("FAIL hold_valid got %0h want 0", instr_valid_d); end
        end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (pc_en !== 1'b1 || pc_next !== 32'h0040_0004) begin bad++; $display("FAIL hold_release_pc got %0h/%h want 1/00400004", pc_en, pc_next); end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (instr_valid_d !== 1'b1 || instr_d !== 32'h8C01_0004) begin bad++; $display("FAIL hold_instr got %0h/%h want 1/8c010004", instr_valid_d, instr_d); end
        total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0040_0004) begin bad++; $display("FAIL hold_refetch got %0h/%h want 1/00400004", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_redirect_drain();
        apply_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h0040_0100, 0, 0, 0);
        total++; if (pc_en !== 1'b1 || pc_next !== 32'h0040_0100) begin bad++; $display("FAIL drain_pc got %0h/%h want 1/00400100", pc_en, pc_next); end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL drain_old_addr got %0h/%h want 1/00400000", imem_bus.imem_req, imem_bus.imem_addr); end
        drive(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        total++; if (pc_en !== 1'b0) begin bad++; $display("FAIL drain_ack_pc_en got %0h want 0", pc_en); end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (instr_valid_d !== 1'b0) begin bad++; $display("FAIL drain_discard got %0h want 0", instr_valid_d); end
        total++; if (imem_bus.imem_addr !== 32'h0040_0100) begin bad++; $display("FAIL drain_new_addr got %h want 00400100", imem_bus.imem_addr); end
        drive(0, 0, 0, 1, 32'h0123_4567, 0);
        drive(0, 0, 0, 0, 0, 0);
        total++; if (instr_d !== 32'h0123_4567 || pc_plus4_d !== 32'h0040_0104) begin bad++; $display("FAIL drain_next_instr got %h/%h want 01234567/00400104", instr_d, pc_plus4_d); end
    endtask

    task automatic test_redirect_ack();
        apply_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h5555_AAAA, 0);
        drive(1, 1, 32'h0040_0203, 1, 32'hAAAA_5555, 0);
        total++; if (pc_en !== 1'b1 || pc_next !== 32'h0040_0200) begin bad++; $display("FAIL rack_pc got %0h/%h want 1/00400200", pc_en, pc_next); end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (instr_valid_d !== 1'b0) begin bad++; $display("FAIL rack_valid got %0h want 0", instr_valid_d); end
        total++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0040_0200) begin bad++; $display("FAIL rack_addr got %0h/%h want 1/00400200", imem_bus.imem_req, imem_bus.imem_addr); end
    endtask

    task automatic test_wrap();
        apply_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'hFFFF_FFFC, 1, 32'h0, 0);
        drive(0, 0, 0, 1, 32'h0BAD_F00D, 0);
        total++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got %h want fffffffc", imem_bus.imem_addr); end
        total++; if (pc_en !== 1'b1 || pc_next !== 32'h0) begin bad++; $display("FAIL wrap_pc_next got %0h/%h want 1/00000000", pc_en, pc_next); end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (pc_plus4_d !== 32'h0 || instr_d !== 32'h0BAD_F00D) begin bad++; $display("FAIL wrap_pc4 got %h/%h want 00000000/0badf00d", pc_plus4_d, instr_d); end
        total++; if (imem_bus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_addr got %h want 0", imem_bus.imem_addr); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 32'h1234_5678, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        apply_reset();
        redirect_valid = 1; redirect_pc = 32'h0000_1000;
        #1;
        total++; if (imem_bus.imem_req !== 1'b0 || pc_en !== 1'b0) begin bad++; $display("FAIL rmid_req_pc_en got %0h/%0h want 0/0", imem_bus.imem_req, pc_en); end
        total++; if (instr_valid_d !== 1'b0 || instr_d !== 32'h0 || pc_plus4_d !== 32'h0) begin bad++; $display("FAIL rmid_decode got %0h/%h/%h want 0/0/0", instr_valid_d, instr_d, pc_plus4_d); end
`ifdef FETCH_CTRL_PERF_EN
        total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL rmid_stall_cnt got %0d want 0", stall_cnt); end
`endif
        drive(0, 0, 0, 1, 32'hFFFF_FFFF, 0);
        total++; if (imem_bus.imem_req !== 1'b0) begin bad++; $display("FAIL rmid_idle_req got %0h want 0", imem_bus.imem_req); end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (instr_valid_d !== 1'b0) begin bad++; $display("FAIL rmid_idle_ack got %0h want 0", instr_valid_d); end
        total++; if (imem_bus.imem_addr !== RPC || imem_bus.imem_req !== 1'b1) begin bad++; $display("FAIL rmid_restart got %h/%0h want 00400000/1", imem_bus.imem_addr, imem_bus.imem_req); end
    endtask

`ifdef FETCH_CTRL_PERF_EN
    task automatic test_perf();
        apply_reset();
        drive(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL perf_cnt got %0d want 5", stall_cnt); end
    endtask
`endif

    task automatic test_random();
        logic st, rd, ak;
        word_t rpc;
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c % 500 == 499) apply_reset();
            st  = ($urandom_range(0, 9) < 3);
            rd  = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : 32'($urandom);
            ak  = ($urandom_range(0, 2) != 0);
            drive(st, rd, rpc, ak, 32'($urandom), 1);
            total++; if (imem_bus.imem_req !== e_req) begin bad++; $display("FAIL rnd_req c=%0d got %0h want %0h", c, imem_bus.imem_req, e_req); end
            if (e_req) begin
                total++; if (imem_bus.imem_addr !== e_addr) begin bad++; $display("FAIL rnd_addr c=%0d got %h want %h", c, imem_bus.imem_addr, e_addr); end
            end
            total++; if (pc_en !== e_pc_en) begin bad++; $display("FAIL rnd_pc_en c=%0d got %0h want %0h", c, pc_en, e_pc_en); end
            if (e_pc_en) begin
                total++; if (pc_next !== e_pc_next) begin bad++; $display("FAIL rnd_pc_next c=%0d got %h want %h", c, pc_next, e_pc_next); end
            end
            total++; if (instr_valid_d !== m_v) begin bad++; $display("FAIL rnd_valid c=%0d got %0h want %0h", c, instr_valid_d, m_v); end
            if (m_v) begin
                total++; if (instr_d !== m_i || pc_plus4_d !== m_p4) begin bad++; $display("FAIL rnd_decode c=%0d got %h/%h want %h/%h", c, instr_d, pc_plus4_d, m_i, m_p4); end
            end
`ifdef FETCH_CTRL_PERF_EN
            total++; if (stall_cnt !== m_cnt) begin bad++; $display("FAIL rnd_stall_cnt c=%0d got %0d want %0d", c, stall_cnt, m_cnt); end
`endif
        end
    endtask

    initial begin
        imem_bus.imem_ack = 0;
        imem_bus.imem_rdata = 0;
        model_reset();
        test_reset();
        test_seq();
        test_hold();
        test_redirect_drain();
        test_redirect_ack();
        test_wrap();
        test_reset_mid();
`ifdef FETCH_CTRL_PERF_EN
        test_perf();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stall_f  input  1  hazard-unit fetch stall; 1 = hold fetch/decode boundary.
REQ-005 redirect_valid  input  1  taken branch/jump from decode, single-cycle pulse.
REQ-006 redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as 0.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  fetch address, word aligned.
REQ-009 imem_ack  input  1  memory response valid, 1+ cycles after request.
REQ-010 imem_rdata  input  32  instruction word, valid with imem_ack.
REQ-011 pc_en  output  1  PC register enable pulse, 1 when fetch PC advances.
REQ-012 pc_next  output  32  value loaded into fetch PC when pc_en=1.
REQ-013 instr_valid_d  output  1  decode-stage instruction valid.
REQ-014 instr_d  output  32  decode-stage instruction.
REQ-015 pc_plus4_d  output  32  fetch PC + 4 of instr_d.
REQ-016 stall_cnt  output  32  stalled-cycle count (FETCH_CTRL_PERF_EN only).

Function
REQ-017 States SHALL be IDLE, FETCH, HOLD, DRAIN; IDLE lasts exactly one cycle after reset release, then FETCH.
REQ-018 In FETCH, imem_req=1 and imem_addr=fetch PC, held stable until imem_ack.
REQ-019 FETCH, imem_ack=1, stall_f=0: instr_d<=imem_rdata, instr_valid_d<=1, pc_plus4_d<=PC+4, pc_en=1, pc_next=PC+4; stay FETCH.
REQ-020 FETCH, imem_ack=1, stall_f=1: buffer word internally, go HOLD; decode outputs unchanged.
REQ-021 HOLD: imem_req=0; on stall_f=0 present buffered word to decode as REQ-019 (pc_en=1), return FETCH.
REQ-022 FETCH, imem_ack=0, stall_f=0: instr_valid_d<=0 (bubble).
REQ-023 stall_f=1 in any state: instr_valid_d, instr_d, pc_plus4_d hold.
REQ-024 redirect_valid SHALL override stall_f and the buffer: pc_en=1, pc_next={redirect_pc[31:2],2'b00}, instr_valid_d<=0, buffered word dropped.
REQ-025 Redirect while request outstanding without ack: go DRAIN; DRAIN holds imem_req=1 at old address until ack, discards the word, then FETCH at new PC.
REQ-026 Redirect in same cycle as imem_ack: returned word discarded, next state FETCH at new PC.
REQ-027 Redirect in DRAIN: newest target wins; stay DRAIN.
REQ-028 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-029 pc_en, pc_next combinational from state and inputs; decode outputs registered.

Reset
REQ-030 rst_n=0 SHALL asynchronously force: state IDLE, fetch PC=RESET_PC, imem_req=0, pc_en=0, instr_valid_d=0, instr_d=0, pc_plus4_d=0, buffer empty, stall_cnt=0.
REQ-031 Reset mid-request SHALL abandon the request; an ack arriving in IDLE is ignored.

Configuration
REQ-032 Macro FETCH_CTRL_PERF_EN defined: stall_cnt increments each cycle stall_f=1 and state!=IDLE, saturates at 32'hFFFF_FFFF.
REQ-033 Macro undefined: stall_cnt port and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-034 Shared package mips_pkg SHALL hold the fetch state enum, RESET_PC default and 32-bit word typedef.
REQ-035 Counter SHALL be sub-module fetch_perf_cnt, instantiated only under FETCH_CTRL_PERF_EN.

Verification
REQ-036 Reset release, ack every cycle -> imem_addr 0x00400000, 0x00400004, 0x00400008; instr_valid_d from cycle 3 after release.
REQ-037 Ack with stall_f=1 for 3 cycles, rdata 0x8C010004 -> HOLD, imem_req=0; instr_d=0x8C010004 one cycle after stall_f drops.
REQ-038 Redirect 0x00400100 while request outstanding, ack 2 cycles later -> returned word never valid; next imem_addr 0x00400100.
REQ-039 Redirect 0x00400203 together with ack and stall_f=1 -> pc_next=0x00400200, instr_valid_d=0.
REQ-040 Fetch at 0xFFFFFFFC acked -> pc_next=0x00000000, pc_plus4_d=0x00000000.
REQ-041 PERF_EN build, stall_f high 5 cycles -> stall_cnt=5; rst_n low mid-request -> all outputs per REQ-030 same cycle.
